// File: rtl/i2c_master_writer.sv
// I2C master write engine: on start, issues START, sends the 7-bit address
// with W=0, drains the byte-wide TX FIFO onto the bus one byte per ACK,
// then issues STOP. SCL/SDA are open-drain, driven through output enables.
module i2c_master_writer #(
  parameter int CLK_DIV    = 250,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [6:0]            slave_addr,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  output logic                  scl_oe,
  output logic                  sda_oe,
  input  logic                  sda_in,
  output logic                  busy,
  output logic                  done,
  output logic                  nack,
  output logic [7:0]            byte_count
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_ADDR_ACK = 3'd3;
  localparam logic [2:0] S_FETCH    = 3'd4;
  localparam logic [2:0] S_DATA     = 3'd5;
  localparam logic [2:0] S_DATA_ACK = 3'd6;
  localparam logic [2:0] S_STOP     = 3'd7;

  logic [2:0]       state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [1:0]       qtr, qtr_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [2:0]       fcnt, fcnt_n;
  logic [6:0]       addr_r, addr_n;
  logic [7:0]       sh, sh_n;
  logic             ack_smp, ack_smp_n;
  logic             nack_flag, nack_flag_n;
  logic [7:0]       byte_count_n;
  logic             busy_n, done_n, nack_n, rd_n;
  logic [1:0]       drive_n;
  logic             qtick, bit_end;

  // Saturating increment for the ACKed-byte counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Line drive {scl_oe, sda_oe} for a given state, quarter and data bit.
  function automatic logic [1:0] line_drive(input logic [2:0] st,
                                            input logic [1:0] q,
                                            input logic       b);
    logic [1:0] d;
    d = 2'b00;
    case (st)
      S_START:                d = (q == 2'd2) ? 2'b01 : ((q == 2'd3) ? 2'b11 : 2'b00);
      S_ADDR, S_DATA:         d = {~q[1], ~b};
      S_ADDR_ACK, S_DATA_ACK: d = {~q[1], 1'b0};
      S_FETCH:                d = 2'b10;
      S_STOP:                 d = (q == 2'd0) ? 2'b11 : ((q == 2'd1) ? 2'b01 : 2'b00);
      default:                d = 2'b00;
    endcase
    return d;
  endfunction

  assign qtick   = (div == DIV_W'(CLK_DIV - 1));
  assign bit_end = qtick && (qtr == 2'd3);

  // Next-state logic: quarter divider, bit sequencing, FIFO fetch, status.
  always_comb begin
    state_n      = state;
    div_n        = div;
    qtr_n        = qtr;
    bit_idx_n    = bit_idx;
    fcnt_n       = fcnt;
    addr_n       = addr_r;
    sh_n         = sh;
    ack_smp_n    = ack_smp;
    nack_flag_n  = nack_flag;
    byte_count_n = byte_count;
    busy_n       = busy;
    done_n       = 1'b0;
    nack_n       = nack;
    rd_n         = 1'b0;

    if (state != S_IDLE && state != S_FETCH) begin
      if (qtick) begin
        div_n = '0;
        qtr_n = qtr + 2'd1;
      end else begin
        div_n = div + DIV_W'(1);
      end
    end

    case (state)
      S_IDLE: begin
        div_n = '0;
        qtr_n = 2'd0;
        // The done cycle itself still counts as busy-adjacent: start ignored.
        if (start && !done) begin
          addr_n       = slave_addr;
          busy_n       = 1'b1;
          byte_count_n = 8'd0;
          nack_flag_n  = 1'b0;
          nack_n       = 1'b0;
          state_n      = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          sh_n      = {addr_r, 1'b0};
          bit_idx_n = 3'd7;
          state_n   = S_ADDR;
        end
      end
      S_ADDR, S_DATA: begin
        if (bit_end) begin
          sh_n = {sh[6:0], 1'b0};
          if (bit_idx == 3'd0)
            state_n = (state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
          else
            bit_idx_n = bit_idx - 3'd1;
        end
      end
      S_ADDR_ACK, S_DATA_ACK: begin
        if (qtick && qtr == 2'd2)
          ack_smp_n = sda_in;
        if (bit_end) begin
          if (ack_smp) begin
            nack_flag_n = 1'b1;
            state_n     = S_STOP;
          end else begin
            if (state == S_DATA_ACK)
              byte_count_n = sat_inc(byte_count);
            fcnt_n  = 3'd0;
            state_n = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        // fcnt 0-1: let the FIFO flag settle; 2: check/pop; 3: pop visible
        // to FIFO; 4: popped word is on fifo_data and gets captured.
        div_n  = '0;
        qtr_n  = 2'd0;
        fcnt_n = fcnt + 3'd1;
        if (fcnt == 3'd2) begin
          if (fifo_empty)
            state_n = S_STOP;
          else
            rd_n = 1'b1;
        end else if (fcnt == 3'd4) begin
          sh_n      = fifo_data[7:0];
          bit_idx_n = 3'd7;
          state_n   = S_DATA;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          nack_n  = nack_flag;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    drive_n = line_drive(state_n, qtr_n, sh_n[7]);
  end

  // Control and output registers; outputs are registered so the pads never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      div          <= '0;
      qtr          <= 2'd0;
      bit_idx      <= 3'd0;
      fcnt         <= 3'd0;
      ack_smp      <= 1'b0;
      nack_flag    <= 1'b0;
      byte_count   <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      nack         <= 1'b0;
      fifo_read_en <= 1'b0;
      scl_oe       <= 1'b0;
      sda_oe       <= 1'b0;
    end else begin
      state        <= state_n;
      div          <= div_n;
      qtr          <= qtr_n;
      bit_idx      <= bit_idx_n;
      fcnt         <= fcnt_n;
      ack_smp      <= ack_smp_n;
      nack_flag    <= nack_flag_n;
      byte_count   <= byte_count_n;
      busy         <= busy_n;
      done         <= done_n;
      nack         <= nack_n;
      fifo_read_en <= rd_n;
      scl_oe       <= drive_n[1];
      sda_oe       <= drive_n[0];
    end
  end

  // Address and shift register hold data only; no reset needed.
  always_ff @(posedge clk) begin
    addr_r <= addr_n;
    sh     <= sh_n;
  end

endmodule

// File: tb/tb_i2c_master_writer.sv
// Bench for i2c_master_writer: FIFO model, bus-level slave that decodes
// START/STOP/bytes from the open-drain lines, and a transaction-level model.
module tb_i2c_master_writer;

  localparam int CDIV = 4;
  localparam int BITP = 4 * CDIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] slave_addr;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_read_en;
  logic       scl_oe, sda_oe, sda_in;
  logic       busy, done, nack;
  logic [7:0] byte_count;

  i2c_master_writer #(.CLK_DIV(CDIV), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .slave_addr(slave_addr),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in),
    .busy(busy), .done(done), .nack(nack), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_read_en) begin
      fifo_data <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
      pops      <= pops + 1;
    end
  end

  // ---------------- Bus slave model ----------------
  bit   cfg_addr_ack = 1'b1;
  int   cfg_nack_at  = -1;
  logic sl_pull = 1'b0;
  logic scl_q = 1'b1, sda_q = 1'b1;
  logic [7:0] sl_sh = 8'h00;
  int sl_bitcnt = 0, sl_frame = 0;
  int cyc = 0, last_rise = 0;
  int gap_ok = 0, gap_bad = 0;
  int start_cnt = 0, stop_cnt = 0;
  logic [7:0] rx_mem [0:127];
  int rx_cnt = 0;
  logic scl_l, sda_l;

  assign scl_l  = ~scl_oe;
  assign sda_l  = ~(sda_oe | sl_pull);
  assign sda_in = sda_l;

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    scl_q <= scl_l;
    sda_q <= sda_l;
    if (scl_q && scl_l && sda_q && !sda_l) begin
      sl_bitcnt <= 0;
      sl_frame  <= 0;
      sl_pull   <= 1'b0;
      start_cnt <= start_cnt + 1;
    end else if (scl_q && scl_l && !sda_q && sda_l) begin
      stop_cnt <= stop_cnt + 1;
    end else if (!scl_q && scl_l) begin
      if (sl_bitcnt < 8) sl_sh <= {sl_sh[6:0], sda_l};
      if (sl_bitcnt > 0) begin
        if (cyc - last_rise == BITP) gap_ok <= gap_ok + 1;
        else gap_bad <= gap_bad + 1;
      end
      last_rise <= cyc;
      sl_bitcnt <= sl_bitcnt + 1;
    end else if (scl_q && !scl_l) begin
      if (sl_bitcnt == 8) begin
        rx_mem[rx_cnt % 128] <= sl_sh;
        rx_cnt   <= rx_cnt + 1;
        sl_frame <= sl_frame + 1;
        sl_pull  <= (sl_frame == 0) ? cfg_addr_ack : ((sl_frame - 1) != cfg_nack_at);
      end else if (sl_bitcnt == 9) begin
        sl_pull   <= 1'b0;
        sl_bitcnt <= 0;
      end
    end
  end

  // ---------------- Transaction-level reference ----------------
  logic [7:0] tdata [0:15];
  logic [7:0] exp_bus [0:31];
  int exp_n, exp_pops, exp_bc, n_load;
  bit exp_nack;
  int b_rx, b_pops, b_stop, b_start, b_gok, b_gbad;

  // Expected bus bytes: address, then each FIFO byte until one is NACKed.
  task automatic model(input logic [6:0] a, input int n, input bit aack, input int nat);
    exp_bus[0] = {a, 1'b0};
    exp_n = 1; exp_pops = 0; exp_bc = 0; exp_nack = !aack;
    if (aack) begin
      for (int i = 0; i < n; i++) begin
        exp_bus[exp_n] = tdata[i];
        exp_n++;
        exp_pops++;
        if (i == nat) begin
          exp_nack = 1'b1;
          break;
        end
        exp_bc = (exp_bc == 255) ? 255 : exp_bc + 1;
      end
    end
  endtask

  task automatic setup(input logic [6:0] a, input int n, input bit aack, input int nat);
    wr_ptr = rd_ptr;
    for (int i = 0; i < n; i++) mem[(wr_ptr + i) % 16] = tdata[i];
    wr_ptr = wr_ptr + n;
    n_load = n;
    slave_addr   = a;
    cfg_addr_ack = aack;
    cfg_nack_at  = nat;
    model(a, n, aack, nat);
    b_rx = rx_cnt; b_pops = pops; b_stop = stop_cnt; b_start = start_cnt;
    b_gok = gap_ok; b_gbad = gap_bad;
  endtask

  task automatic launch(input string nm);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({nm, "_busy_on"}, busy, 1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_txn(input string nm, input bit ok);
    chk({nm, "_done"}, ok, 1);
    chk({nm, "_nack"}, nack, exp_nack);
    chk({nm, "_bcnt"}, byte_count, exp_bc);
    chk({nm, "_busy_off"}, busy, 0);
    chk({nm, "_nbytes"}, rx_cnt - b_rx, exp_n);
    for (int i = 0; i < exp_n && i < 32; i++)
      chk({nm, "_byte"}, rx_mem[(b_rx + i) % 128], exp_bus[i]);
    chk({nm, "_pops"}, pops - b_pops, exp_pops);
    chk({nm, "_left"}, wr_ptr - rd_ptr, n_load - exp_pops);
    chk({nm, "_starts"}, start_cnt - b_start, 1);
    chk({nm, "_stops"}, stop_cnt - b_stop, 1);
    chk({nm, "_gaps16"}, gap_ok - b_gok, 8 * exp_n);
    chk({nm, "_gapbad"}, gap_bad - b_gbad, 0);
  endtask

  task automatic run(input string nm, input logic [6:0] a, input int n, input bit aack, input int nat);
    bit ok;
    setup(a, n, aack, nat);
    launch(nm);
    wait_done(ok);
    check_txn(nm, ok);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
  endtask

  initial begin
    bit ok;
    bit found;
    rst_n = 1'b0; start = 1'b0; slave_addr = 7'h00;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    chk("rst_rd", fifo_read_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    chk("rst_bcnt", byte_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two bytes, all ACKed.
    tdata[0] = 8'hA5; tdata[1] = 8'h3C;
    run("basic", 7'h50, 2, 1'b1, -1);

    // Address NACK.
    tdata[0] = 8'h77;
    run("addr_nack", 7'h27, 1, 1'b0, -1);

    // Data NACK on the second of three bytes; third stays in FIFO.
    tdata[0] = 8'h11; tdata[1] = 8'h22; tdata[2] = 8'h33;
    run("data_nack", 7'h12, 3, 1'b1, 1);

    // Empty FIFO: zero-byte write.
    run("empty", 7'h50, 0, 1'b1, -1);

    // Reset in the middle of the second data byte.
    tdata[0] = 8'h81; tdata[1] = 8'h42; tdata[2] = 8'hC3;
    setup(7'h3A, 3, 1'b1, -1);
    launch("rst_mid");
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sl_frame == 2 && sl_bitcnt == 3) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached", found, 1);
    chk("rst_mid_bcnt_before", byte_count, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_scl", scl_oe, 0);
    chk("rst_mid_sda", sda_oe, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_bcnt", byte_count, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tdata[0] = 8'h5E; tdata[1] = 8'h01;
    run("post_rst", 7'h6B, 2, 1'b1, -1);

    // Start while busy (with a different address) and on the done cycle.
    tdata[0] = 8'hF0; tdata[1] = 8'h0F;
    setup(7'h44, 2, 1'b1, -1);
    launch("busy_start");
    repeat (40) @(negedge clk);
    slave_addr = 7'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_still_busy", busy, 1);
    wait_done(ok);
    check_txn("busy_start", ok);
    setup(7'h2D, 0, 1'b1, -1);
    start = 1'b1;
    @(negedge clk);
    chk("done_cycle_start_ignored", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("next_start_accepted", busy, 1);
    wait_done(ok);
    check_txn("late_start", ok);
    @(negedge clk);

    // Randomized transactions.
    for (int t = 0; t < 5; t++) begin
      int n, nat;
      bit aack;
      logic [6:0] a;
      a    = 7'($urandom_range(0, 127));
      n    = $urandom_range(0, 4);
      aack = ($urandom_range(0, 3) != 0);
      nat  = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      for (int i = 0; i < n; i++) tdata[i] = 8'($urandom_range(0, 255));
      run("rand", a, n, aack, nat);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_master_writer.md
Name: i2c_master_writer

Overview:
- I2C master write engine that drains the byte-wide TX FIFO onto the bus.
- On a start pulse it issues START, sends the 7-bit address with W=0, then pops and sends FIFO bytes until the FIFO is empty, then issues STOP.
- Sits directly downstream of the TX FIFO: drives its read_en, consumes its registered data_out and fifo_empty.
- Drives open-drain SCL/SDA pads via output-enable signals.

Parameters:
- CLK_DIV, 250: clk cycles per quarter SCL bit period (≥2); bit period = 4*CLK_DIV.
- DATA_WIDTH, 8: FIFO word width; fixed at 8 for I2C.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy=1.
- slave_addr  in  7  target address, captured on accepted start.
- fifo_data  in  8  FIFO data_out; valid 1 clk after fifo_read_en.
- fifo_empty  in  1  FIFO empty flag; lags FIFO state by up to 2 clk.
- fifo_read_en  out  1  one-cycle pop strobe to FIFO.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- sda_in  in  1  sampled SDA pad value (pre-synchronised).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of transaction.
- nack  out  1  valid with done; 1 = address or data NACK aborted the transfer.
- byte_count  out  8  data bytes ACKed in the current/last transaction; saturates at 255.

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, fifo_read_en=0, busy=0, done=0, nack=0, byte_count=0, state IDLE, divider 0. Reset mid-transfer releases both lines next clk; no STOP is generated.
- Quarter tick: divider counts 0..CLK_DIV-1 and runs only when not IDLE. Each bit spans quarters Q0..Q3.
- Bit timing: SCL low in Q0–Q1, released in Q2–Q3. SDA changes only at Q0 entry. sda_in is sampled on the last clk of Q2.
- States:
  - IDLE: on start, capture slave_addr, set busy=1, clear byte_count, go to START.
  - START: Q0–Q1 SCL and SDA released; Q2 sda_oe=1 with SCL released; Q3 SCL low. Then ADDR.
  - ADDR: 8 bits MSB first, {slave_addr, 1'b0}. sda_oe = ~bit. Then ADDR_ACK.
  - ADDR_ACK: SDA released. sda_in=0 goes to FETCH; sda_in=1 sets nack_flag and goes to STOP.
  - FETCH: SCL held low. Wait 2 clk for the FIFO flag to settle, then check fifo_empty.
    - Empty: go to STOP.
    - Otherwise: pulse fifo_read_en for 1 clk, capture fifo_data on the following clk into the shift register, restart the divider at Q0, go to DATA.
    - Exactly one pop per byte.
  - DATA: 8 bits MSB first, as ADDR. Then DATA_ACK.
  - DATA_ACK: SDA released. sda_in=0 increments byte_count (saturating) and goes to FETCH; sda_in=1 sets nack_flag and goes to STOP. A NACKed byte is not counted and is not re-sent.
  - STOP: Q0 sda_oe=1, SCL low; Q1 SCL released, SDA low; Q2–Q3 both released. Then IDLE.
    - On IDLE entry: done=1 for 1 clk, nack=nack_flag, busy=0.
- FIFO empty at ADDR_ACK success: zero-byte write (START, addr, STOP), done with byte_count=0.
- Start asserted during busy or on the done cycle: ignored. A new start is accepted from the first clk in IDLE after done.
- No clock stretching, no arbitration; SCL is never read back.

Test Plan:
- CLK_DIV=4, FIFO preloaded with 0xA5, 0x3C; start with slave_addr=0x50; slave ACKs all -> SDA bits 1010_0000 then ACK, 10100101, 00111100; exactly 2 fifo_read_en pulses; done with nack=0, byte_count=2; each bit lasts 16 clk.
- Address NACK: sda_in held 1, slave_addr=0x27 -> STOP follows ADDR_ACK; zero fifo_read_en pulses; done with nack=1, byte_count=0.
- Data NACK on 2nd of 3 bytes (0x11, 0x22, 0x33) -> 2 pops, STOP, nack=1, byte_count=1; 0x33 remains in the FIFO.
- Empty FIFO, start, ACK -> START, 0xA0 on bus, STOP; done with byte_count=0; fifo_read_en never asserted.
- Reset asserted mid-DATA bit 3 -> next clk scl_oe=0, sda_oe=0, busy=0, byte_count=0; a subsequent start runs a clean transaction.
- Start pulsed while busy, and again on the done cycle -> both ignored; a single transaction only; a start 1 clk later is accepted.
